// File: rtl/divbyn_pkg.sv
// Shared constants for the serial divisibility checker: divisor bounds,
// bit-order encoding and the remainder-width derivation.
package divbyn_pkg;

  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 255;

  typedef enum logic {
    MODE_MSB = 1'b0,
    MODE_LSB = 1'b1
  } mode_e;

  // ceil(log2(divisor)); bounded loop keeps it a legal constant function
  function automatic int rem_w_f(input int divisor);
    int w;
    w = 0;
    for (int i = 0; i < 9; i++) begin
      if ((1 << w) < divisor) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/divbyn_serial_if.sv
// Bit-stream input and divisibility result bundle for divbyn_serial.
interface divbyn_serial_if #(
  parameter int DIVISOR = 3,
  parameter int CNT_W   = 8
);
  localparam int REM_W = divbyn_pkg::rem_w_f(DIVISOR);

  logic             in_valid;
  logic             in_bit;
  logic             clr;
  logic             lsb_first;
  logic             out;
  logic [REM_W-1:0] rem;
  logic [CNT_W-1:0] nbits;

  modport master (output in_valid, in_bit, clr, lsb_first,
                  input  out, rem, nbits);
  modport slave  (input  in_valid, in_bit, clr, lsb_first,
                  output out, rem, nbits);

endinterface

// File: rtl/divbyn_modadd.sv
// Combinational (a + b) mod DIVISOR for operands already below DIVISOR:
// one extra carry bit and a single conditional subtract.
module divbyn_modadd
  import divbyn_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int REM_W   = rem_w_f(DIVISOR)
) (
  input  logic [REM_W-1:0] a,
  input  logic [REM_W-1:0] b,
  output logic [REM_W-1:0] sum
);

  localparam logic [REM_W:0] DIV_EXT = (REM_W+1)'(DIVISOR);

  logic [REM_W:0] raw;
  logic [REM_W:0] reduced;

  always_comb begin
    raw     = {1'b0, a} + {1'b0, b};
    reduced = raw - DIV_EXT;
    sum     = (raw >= DIV_EXT) ? reduced[REM_W-1:0] : raw[REM_W-1:0];
  end

endmodule

// File: rtl/divbyn_serial.sv
// Serial divisibility checker: accumulates a bit stream (MSB- or LSB-first)
// as a running remainder modulo DIVISOR and flags when it reaches zero.
//
// mode_q   | meaning
// MODE_MSB | each bit doubles the remainder, then adds the bit
// MODE_LSB | each bit adds bit*weight; weight doubles mod DIVISOR
module divbyn_serial
  import divbyn_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int CNT_W   = 8
) (
  input logic            clk,
  input logic            rstn,
  divbyn_serial_if.slave bus
);

  localparam int REM_W = rem_w_f(DIVISOR);
  localparam logic [REM_W-1:0] W_ONE = REM_W'(1);

  logic [REM_W-1:0] rem_q, rem_d;
  logic [REM_W-1:0] weight_q, weight_d;
  mode_e            mode_q, mode_d;
  logic [CNT_W-1:0] nbits_q, nbits_d;
  logic             out_q, out_d;

  // clr takes effect before a same-cycle accept, so the datapath sees cleared operands
  logic [REM_W-1:0] rem_base;
  logic [REM_W-1:0] weight_base;
  logic [REM_W-1:0] rem_dbl;
  logic [REM_W-1:0] msb_sum;
  logic [REM_W-1:0] lsb_term;
  logic [REM_W-1:0] lsb_sum;
  logic [REM_W-1:0] weight_dbl;

  assign rem_base    = bus.clr ? '0 : rem_q;
  assign weight_base = bus.clr ? W_ONE : weight_q;
  assign lsb_term    = bus.in_bit ? weight_base : '0;

  divbyn_modadd #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_rem_dbl (
    .a   (rem_base),
    .b   (rem_base),
    .sum (rem_dbl)
  );

  divbyn_modadd #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_msb_add (
    .a   (rem_dbl),
    .b   (REM_W'(bus.in_bit)),
    .sum (msb_sum)
  );

  divbyn_modadd #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_lsb_add (
    .a   (rem_base),
    .b   (lsb_term),
    .sum (lsb_sum)
  );

  divbyn_modadd #(.DIVISOR(DIVISOR), .REM_W(REM_W)) u_weight_dbl (
    .a   (weight_base),
    .b   (weight_base),
    .sum (weight_dbl)
  );

  always_comb begin
    rem_d    = rem_q;
    weight_d = weight_q;
    mode_d   = mode_q;
    nbits_d  = nbits_q;
    out_d    = out_q;

    if (bus.clr) begin
      rem_d    = '0;
      weight_d = W_ONE;
      nbits_d  = '0;
    end

    if (bus.in_valid) begin
      // bit order is latched only on the first bit of a number
      if (nbits_d == '0) mode_d = mode_e'(bus.lsb_first);
      if (mode_d == MODE_MSB) begin
        rem_d = msb_sum;
      end else begin
        rem_d    = lsb_sum;
        weight_d = weight_dbl;
      end
      if (nbits_d != '1) nbits_d = nbits_d + 1'b1;
    end

    out_d = (rem_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rem_q    <= '0;
      weight_q <= W_ONE;
      mode_q   <= MODE_MSB;
      nbits_q  <= '0;
      out_q    <= 1'b1;
    end else begin
      rem_q    <= rem_d;
      weight_q <= weight_d;
      mode_q   <= mode_d;
      nbits_q  <= nbits_d;
      out_q    <= out_d;
    end
  end

  assign bus.rem   = rem_q;
  assign bus.out   = out_q;
  assign bus.nbits = nbits_q;

endmodule

// File: tb/tb_divbyn_serial.sv
// Drives one bit stream into three divbyn_serial instances (mod 3, 5, 7/CNT_W=4)
// and checks each against its own reference model through a scoreboard.
module tb_divbyn_serial;

  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn      = 1'b0;
  logic in_valid  = 1'b0;
  logic in_bit    = 1'b0;
  logic clr       = 1'b0;
  logic lsb_first = 1'b0;

  divbyn_serial_if #(.DIVISOR(3), .CNT_W(8)) if0 ();
  divbyn_serial_if #(.DIVISOR(5), .CNT_W(8)) if1 ();
  divbyn_serial_if #(.DIVISOR(7), .CNT_W(4)) if2 ();

  assign if0.in_valid = in_valid;  assign if0.in_bit = in_bit;
  assign if0.clr = clr;            assign if0.lsb_first = lsb_first;
  assign if1.in_valid = in_valid;  assign if1.in_bit = in_bit;
  assign if1.clr = clr;            assign if1.lsb_first = lsb_first;
  assign if2.in_valid = in_valid;  assign if2.in_bit = in_bit;
  assign if2.clr = clr;            assign if2.lsb_first = lsb_first;

  divbyn_serial #(.DIVISOR(3), .CNT_W(8)) dut0 (.clk(clk), .rstn(rstn), .bus(if0));
  divbyn_serial #(.DIVISOR(5), .CNT_W(8)) dut1 (.clk(clk), .rstn(rstn), .bus(if1));
  divbyn_serial #(.DIVISOR(7), .CNT_W(4)) dut2 (.clk(clk), .rstn(rstn), .bus(if2));

  logic [7:0] obs_rem [N];
  logic [7:0] obs_n   [N];
  logic       obs_out [N];

  assign obs_rem[0] = 8'(if0.rem);  assign obs_n[0] = 8'(if0.nbits);  assign obs_out[0] = if0.out;
  assign obs_rem[1] = 8'(if1.rem);  assign obs_n[1] = 8'(if1.nbits);  assign obs_out[1] = if1.out;
  assign obs_rem[2] = 8'(if2.rem);  assign obs_n[2] = 8'(if2.nbits);  assign obs_out[2] = if2.out;

  typedef struct {
    int rem;
    bit out;
    int nbits;
  } exp_t;

  exp_t sb_q [N][$];

  int m_div [N] = '{3, 5, 7};
  int m_max [N] = '{255, 255, 15};
  int m_rem [N];
  int m_w   [N];
  int m_mode[N];
  int m_n   [N];

  int checks = 0;
  int errors = 0;

  // One clock of stimulus; the model advances and the expectation is queued
  task automatic step(input logic v, input logic b, input logic c, input logic l, input logic r);
    @(negedge clk);
    in_valid = v; in_bit = b; clr = c; lsb_first = l; rstn = r;
    for (int i = 0; i < N; i++) begin
      exp_t e;
      if (!r) begin
        m_rem[i] = 0; m_w[i] = 1; m_mode[i] = 0; m_n[i] = 0;
      end else begin
        if (c) begin
          m_rem[i] = 0; m_w[i] = 1; m_n[i] = 0;
        end
        if (v) begin
          if (m_n[i] == 0) m_mode[i] = int'(l);
          if (m_mode[i] == 0) begin
            m_rem[i] = (2 * m_rem[i] + int'(b)) % m_div[i];
          end else begin
            m_rem[i] = (m_rem[i] + (b ? m_w[i] : 0)) % m_div[i];
            m_w[i]   = (2 * m_w[i]) % m_div[i];
          end
          if (m_n[i] < m_max[i]) m_n[i] = m_n[i] + 1;
        end
      end
      e.rem = m_rem[i]; e.out = (m_rem[i] == 0); e.nbits = m_n[i];
      sb_q[i].push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (sb_q[i].size() > 0) begin
        exp_t e;
        e = sb_q[i].pop_front();
        checks++;
        if (obs_rem[i] !== 8'(e.rem) || obs_out[i] !== e.out || obs_n[i] !== 8'(e.nbits)) begin
          errors++;
          $display("FAIL scoreboard div%0d: got rem=%0d out=%0b nbits=%0d, want rem=%0d out=%0b nbits=%0d",
                   m_div[i], obs_rem[i], obs_out[i], obs_n[i], e.rem, e.out, e.nbits);
        end
      end
    end
  end

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      checks++;
      if (obs_rem[i] !== 8'd0 || obs_out[i] !== 1'b1 || obs_n[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_state div%0d: got rem=%0d out=%0b nbits=%0d, want 0/1/0",
                 m_div[i], obs_rem[i], obs_out[i], obs_n[i]);
      end
    end
  endtask

  task automatic test_msb_basic();
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_rem[0] !== 8'd1 || obs_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL msb_bit1: got rem=%0d out=%0b, want rem=1 out=0", obs_rem[0], obs_out[0]);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_rem[0] !== 8'd0 || obs_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL msb_bit2: got rem=%0d out=%0b, want rem=0 out=1", obs_rem[0], obs_out[0]);
    end
  endtask

  task automatic test_lsb_clr();
    int exp_rem [3] = '{1, 1, 2};
    logic [2:0] bits = 3'b101;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, bits[k], 1'b0, 1'b1, 1'b1);
      checks++;
      if (obs_rem[0] !== 8'(exp_rem[k])) begin
        errors++;
        $display("FAIL lsb_rem bit%0d: got %0d, want %0d", k, obs_rem[0], exp_rem[k]);
      end
    end
    checks++;
    if (obs_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL lsb_out_end: got %0b, want 0", obs_out[0]);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_out[0] !== 1'b1 || obs_n[0] !== 8'd0 || obs_rem[0] !== 8'd0) begin
      errors++;
      $display("FAIL clr_only: got rem=%0d out=%0b nbits=%0d, want 0/1/0", obs_rem[0], obs_out[0], obs_n[0]);
    end
  endtask

  task automatic test_gaps();
    int exp_rem [4] = '{1, 2, 0, 0};
    logic [3:0] bits = 4'b0101;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, bits[k], 1'b0, 1'b0, 1'b1);
      for (int g = 0; g < 2; g++) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b1);
        checks++;
        if (obs_rem[1] !== 8'(exp_rem[k]) || obs_n[1] !== 8'(k + 1)) begin
          errors++;
          $display("FAIL gap_hold bit%0d: got rem=%0d nbits=%0d, want rem=%0d nbits=%0d",
                   k, obs_rem[1], obs_n[1], exp_rem[k], k + 1);
        end
      end
    end
    checks++;
    if (obs_rem[1] !== 8'd0 || obs_out[1] !== 1'b1 || obs_n[1] !== 8'd4) begin
      errors++;
      $display("FAIL gap_final: got rem=%0d out=%0b nbits=%0d, want 0/1/4", obs_rem[1], obs_out[1], obs_n[1]);
    end
  endtask

  task automatic test_clr_accept();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (obs_rem[0] !== 8'd1 || obs_n[0] !== 8'd1) begin
      errors++;
      $display("FAIL clr_accept: got rem=%0d nbits=%0d, want rem=1 nbits=1", obs_rem[0], obs_n[0]);
    end
    // LSB gives 1 here, MSB would give 2
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_rem[0] !== 8'd1 || obs_n[0] !== 8'd2) begin
      errors++;
      $display("FAIL mode_locked: got rem=%0d nbits=%0d, want rem=1 nbits=2", obs_rem[0], obs_n[0]);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_rem[0] !== 8'd1 || obs_n[0] !== 8'd1 || obs_out[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got rem=%0d nbits=%0d out=%0b, want 1/1/0", obs_rem[0], obs_n[0], obs_out[0]);
    end
  endtask

  task automatic test_saturate();
    int want_rem;
    want_rem = ((1 << 20) - 1) % 7;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (obs_n[2] !== 8'd15 || obs_rem[2] !== 8'(want_rem) || obs_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL saturate: got nbits=%0d rem=%0d out=%0b, want nbits=15 rem=%0d out=0",
               obs_n[2], obs_rem[2], obs_out[2], want_rem);
    end
  endtask

  task automatic test_random(input logic mode);
    int accepted = 0;
    step(1'b0, 1'b0, 1'b1, mode, 1'b1);
    while (accepted < 1000) begin
      logic v, b, c, l;
      v = ($urandom_range(0, 3) != 0);
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 63) == 0);
      l = (c || m_n[0] == 0) ? mode : 1'($urandom_range(0, 1));
      step(v, b, c, l, 1'b1);
      if (v) accepted++;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_rem[i] = 0; m_w[i] = 1; m_mode[i] = 0; m_n[i] = 0;
    end
    test_reset();
    test_msb_basic();
    test_lsb_clr();
    test_gaps();
    test_clr_accept();
    test_reset_mid();
    test_saturate();
    test_random(1'b0);
    test_random(1'b1);
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
